// File: rtl/wb_pkg.sv
// Shared defaults and the buffered-result entry for the writeback arbiter.
package wb_pkg;

   localparam int DATA_WIDTH_DEF     = 32;
   localparam int REG_DATA_WIDTH_DEF = 5;
   localparam int FIFO_DEPTH_DEF     = 2;

   typedef struct packed {
      logic [REG_DATA_WIDTH_DEF-1:0] rd;
      logic [DATA_WIDTH_DEF-1:0]     data;
   } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU/multi-cycle requests, register-file write port, decode query.
// busy_mask/stall are only live when WB_SCOREBOARD_EN is defined.
interface wb_arbiter_if
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int REG_DATA_WIDTH = REG_DATA_WIDTH_DEF
);
   localparam int NREGS = 2**REG_DATA_WIDTH;

   logic                      alu_valid;
   logic [REG_DATA_WIDTH-1:0] alu_rd;
   logic [DATA_WIDTH-1:0]     alu_data;
   logic                      mc_issue;
   logic [REG_DATA_WIDTH-1:0] mc_issue_rd;
   logic                      mc_valid;
   logic [REG_DATA_WIDTH-1:0] mc_rd;
   logic [DATA_WIDTH-1:0]     mc_data;
   logic                      mc_ready;
   logic                      RegWrite;
   logic [REG_DATA_WIDTH-1:0] rd;
   logic [DATA_WIDTH-1:0]     ResultW;
   logic [REG_DATA_WIDTH-1:0] rs1;
   logic [REG_DATA_WIDTH-1:0] rs2;
   logic                      stall;
   logic [NREGS-1:0]          busy_mask;

   modport master (
      output alu_valid, alu_rd, alu_data, mc_issue, mc_issue_rd,
             mc_valid, mc_rd, mc_data, rs1, rs2,
      input  mc_ready, RegWrite, rd, ResultW, stall, busy_mask
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, mc_issue, mc_issue_rd,
             mc_valid, mc_rd, mc_data, rs1, rs2,
      output mc_ready, RegWrite, rd, ResultW, stall, busy_mask
   );

endinterface

// File: rtl/wb_fifo.sv
// In-order buffer for multi-cycle results; DEPTH must be a power of two >= 2.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int ENTRY_W = $bits(wb_entry_t),
   parameter int DEPTH   = FIFO_DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [ENTRY_W-1:0] din,
   output logic               full,
   output logic               empty,
   output logic [ENTRY_W-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][ENTRY_W-1:0] mem;
   logic [AW-1:0]                 wr_ptr, rd_ptr;
   logic [AW:0]                   cnt;
   logic                          do_push, do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win the register-file port, multi-cycle results drain
// from a FIFO in idle ALU cycles. Define WB_SCOREBOARD_EN to enable busy tracking/stall.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int REG_DATA_WIDTH = REG_DATA_WIDTH_DEF,
   parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
   input  logic         clk,
   input  logic         rst,
   wb_arbiter_if.slave  bus
);
   localparam int NREGS = 2**REG_DATA_WIDTH;

   // Same shape as wb_entry_t, but sized by this instance's parameters.
   typedef struct packed {
      logic [REG_DATA_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0]     data;
   } entry_t;

   entry_t                    push_e, head_e;
   logic                      full, empty, push, pop;
   logic                      reg_write_q;
   logic [REG_DATA_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0]     result_q;

   assign push_e       = '{rd: bus.mc_rd, data: bus.mc_data};
   assign bus.mc_ready = !full;
   assign push         = bus.mc_valid && !full;
   assign pop          = !bus.alu_valid && !empty;

   wb_fifo #(
      .ENTRY_W ($bits(entry_t)),
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_e),
      .full  (full),
      .empty (empty),
      .head  (head_e)
   );

   // Writes to x0 are consumed but never asserted on the port.
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_q <= 1'b0;
         rd_q        <= '0;
         result_q    <= '0;
      end else if (bus.alu_valid) begin
         reg_write_q <= (bus.alu_rd != '0);
         rd_q        <= bus.alu_rd;
         result_q    <= bus.alu_data;
      end else if (!empty) begin
         reg_write_q <= (head_e.rd != '0);
         rd_q        <= head_e.rd;
         result_q    <= head_e.data;
      end else begin
         reg_write_q <= 1'b0;
      end
   end

   assign bus.RegWrite = reg_write_q;
   assign bus.rd       = rd_q;
   assign bus.ResultW  = result_q;

`ifdef WB_SCOREBOARD_EN
   logic [NREGS-1:0] busy_q, busy_d;

   // Clear first so a same-cycle issue to the draining register keeps it busy.
   always_comb begin
      busy_d = busy_q;
      if (pop && head_e.rd != '0)
         busy_d[head_e.rd] = 1'b0;
      if (bus.mc_issue && bus.mc_issue_rd != '0)
         busy_d[bus.mc_issue_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign bus.busy_mask = busy_q;
   assign bus.stall     = (bus.rs1 != '0 && busy_q[bus.rs1]) ||
                          (bus.rs2 != '0 && busy_q[bus.rs2]);
`else
   logic unused_sb;
   assign unused_sb     = ^{bus.mc_issue, bus.mc_issue_rd, bus.rs1, bus.rs2};
   assign bus.busy_mask = '0;
   assign bus.stall     = 1'b0;
`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register data width.
REQ-002 Parameter REG_DATA_WIDTH, default 5, register address width (2**REG_DATA_WIDTH registers).
REQ-003 Parameter FIFO_DEPTH, default 2, multi-cycle result buffer entries (power of two, >=2).
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 alu_valid  in  1  ALU-pipe writeback request this cycle; no backpressure.
REQ-008 alu_rd  in  REG_DATA_WIDTH  ALU destination register.
REQ-009 alu_data  in  DATA_WIDTH  ALU result.
REQ-010 mc_issue, mc_issue_rd  in  1 / REG_DATA_WIDTH  multi-cycle op issued, destination marked busy.
REQ-011 mc_valid, mc_rd, mc_data  in  1 / REG_DATA_WIDTH / DATA_WIDTH  multi-cycle result offer.
REQ-012 mc_ready  out  1  multi-cycle result accepted when mc_valid && mc_ready.
REQ-013 RegWrite, rd, ResultW  out  1 / REG_DATA_WIDTH / DATA_WIDTH  registered write port to register file.
REQ-014 rs1, rs2  in  REG_DATA_WIDTH  decode source-register query.
REQ-015 stall  out  1  decode must hold; busy_mask  out  2**REG_DATA_WIDTH  per-register busy bits.

Function
REQ-016 ALU priority: alu_valid at cycle N SHALL produce RegWrite=1, rd=alu_rd, ResultW=alu_data in cycle N+1.
REQ-017 mc_ready SHALL equal !fifo_full (combinational from state only, not from mc_valid).
REQ-018 An accepted multi-cycle result SHALL be pushed into the FIFO in order; FIFO head SHALL drain to the write port only in cycles with alu_valid=0.
REQ-019 Minimum multi-cycle latency: pushed at N into empty FIFO, alu_valid=0 at N+1 -> RegWrite=1 in N+2.
REQ-020 If alu_valid=0 and FIFO empty, next-cycle RegWrite SHALL be 0; rd and ResultW hold previous values.
REQ-021 Any write with destination 0 SHALL give RegWrite=0 (FIFO entry still popped, ALU request still consumed).
REQ-022 Push and pop in the same cycle SHALL both take effect; occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-023 Busy bit SHALL set on mc_issue for mc_issue_rd != 0; clear when the FIFO entry for that rd drains.
REQ-024 Set and clear of the same register in the same cycle: set SHALL win.
REQ-025 stall SHALL be 1 iff (rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]); combinational.
REQ-026 ALU write to a busy register SHALL still be performed; busy bit unchanged.

Reset
REQ-027 rst SHALL clear RegWrite, rd, ResultW to 0, empty the FIFO, clear all busy bits; mc_ready=1 in the first cycle after reset.
REQ-028 rst mid-operation SHALL discard buffered results without writing them; inputs during rst are ignored.

Configuration
REQ-029 Macro WB_SCOREBOARD_EN defined: busy tracking, busy_mask and stall as specified.
REQ-030 WB_SCOREBOARD_EN undefined: no busy state; busy_mask=0, stall=0; mc_issue/mc_issue_rd ignored; write path unchanged.

Structure
REQ-031 Package wb_pkg SHALL hold DATA_WIDTH/REG_DATA_WIDTH defaults and the FIFO entry struct {rd, data}.
REQ-032 FIFO SHALL be sub-module wb_fifo (push/pop/full/empty/head); arbitration and scoreboard stay in wb_arbiter.

Verification
REQ-033 alu_valid=1, alu_rd=5, alu_data=0x1234 at N -> RegWrite=1, rd=5, ResultW=0x1234 at N+1.
REQ-034 mc push rd=7/0xAA while alu_valid=1 for 3 cycles -> no mc write during those cycles; rd=7 written the cycle after alu_valid drops.
REQ-035 Three mc_valid offers with DEPTH=2, alu_valid held 1 -> mc_ready=0 after 2 accepts; third accepted after first drain; write order 1,2,3.
REQ-036 mc_issue rd=9, rs1=9 -> stall=1 until rd=9 written; stall=0 the cycle after; rs1=0 never stalls.
REQ-037 alu_rd=0 or mc_rd=0 -> RegWrite stays 0; FIFO occupancy decreases.
REQ-038 rst asserted with 2 FIFO entries and busy bits set -> no writes follow, busy_mask=0, mc_ready=1, outputs 0.
